// File: rtl/div_strobe_sel.sv
// Turns rising edges of a selected divider tap into single-cycle enable strobes,
// with a handshaked ratio change that only commits on a genuine edge of the new tap.
module div_strobe_sel #(
  parameter int         CNT_W   = 8,
  parameter int         TIMEOUT = 64,
  parameter logic [1:0] RST_SEL = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       div_in,
  input  logic             sel_req,
  input  logic [1:0]       sel_new,
  input  logic             cnt_clr,
  output logic             strobe,
  output logic [1:0]       sel_cur,
  output logic             sel_ack,
  output logic             sel_err,
  output logic             busy,
  output logic [CNT_W-1:0] strobe_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t        state;
  logic [3:0]    d1;
  logic [3:0]    d2;
  logic [1:0]    prime_sr;
  logic [1:0]    pend;
  logic [TW-1:0] tcnt;
  logic [3:0]    rise;

  // Edges are masked until both history stages hold real samples after reset.
  assign rise = d1 & ~d2 & {4{prime_sr[1]}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      d1         <= '0;
      d2         <= '0;
      prime_sr   <= '0;
      pend       <= '0;
      tcnt       <= '0;
      strobe     <= 1'b0;
      sel_cur    <= RST_SEL;
      sel_ack    <= 1'b0;
      sel_err    <= 1'b0;
      busy       <= 1'b0;
      strobe_cnt <= '0;
    end else begin
      d1       <= div_in;
      d2       <= d1;
      prime_sr <= {prime_sr[0], 1'b1};
      strobe   <= 1'b0;
      sel_ack  <= 1'b0;
      sel_err  <= 1'b0;

      if (cnt_clr)
        strobe_cnt <= '0;
      else if (strobe)
        strobe_cnt <= strobe_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          strobe <= rise[sel_cur];
          if (sel_req) begin
            if (sel_new == sel_cur) begin
              sel_ack <= 1'b1;
            end else begin
              pend  <= sel_new;
              tcnt  <= '0;
              state <= PENDING;
              busy  <= 1'b1;
            end
          end
        end
        PENDING: begin
          // Commit only on a real edge of the new tap so the first strobe is a full period.
          if (rise[pend]) begin
            sel_cur <= pend;
            strobe  <= 1'b1;
            sel_ack <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            sel_ack <= 1'b1;
            sel_err <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_strobe_sel.sv
// Directed checks of div_strobe_sel: priming, cadence, ratio switch, timeout, counter wrap/clear, reset abort.
module tb_div_strobe_sel;

  logic       clk;
  logic       rst;
  logic [3:0] div_in;
  logic       sel_req;
  logic [1:0] sel_new;
  logic       cnt_clr;
  logic       strobe;
  logic [1:0] sel_cur;
  logic       sel_ack;
  logic       sel_err;
  logic       busy;
  logic [7:0] strobe_cnt;

  int checks = 0;
  int errors = 0;
  int k;
  bit cnt_run;
  int n_strb, n_ack, n_busy, n_nbusy;

  div_strobe_sel #(.CNT_W(8), .TIMEOUT(64), .RST_SEL(2'd0)) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .sel_req(sel_req), .sel_new(sel_new),
    .cnt_clr(cnt_clr), .strobe(strobe), .sel_cur(sel_cur), .sel_ack(sel_ack),
    .sel_err(sel_err), .busy(busy), .strobe_cnt(strobe_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: outputs of edge k are stable afterwards; inputs set afterwards are sampled at edge k+1.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    if (cnt_run) div_in = div_in + 4'd1;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_strb = 0; n_ack = 0; n_busy = 0; n_nbusy = 0;
  endtask

  task automatic acc_counts();
    n_strb  += int'(strobe);
    n_ack   += int'(sel_ack);
    n_busy  += int'(busy);
    n_nbusy += int'(!busy);
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt_run = 1'b0; div_in = 4'd0; sel_req = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; div_in = 4'd0; sel_req = 1'b0; sel_new = 2'd0; cnt_clr = 1'b0;
    cnt_run = 1'b0; k = 0;

    // Reset state
    do_reset();
    chk("rst_strobe", 32'(strobe), 0);
    chk("rst_ack", 32'(sel_ack), 0);
    chk("rst_err", 32'(sel_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(strobe_cnt), 0);
    chk("rst_sel", 32'(sel_cur), 0);

    // Counter starts at 1 so an unprimed detector would fire at edge 1; first real edge at 3.
    rst = 1'b0; div_in = 4'd1; cnt_run = 1'b1; k = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("cadence_sel0", 32'(strobe), (k >= 3 && (k % 2) == 1) ? 1 : 0);
      if (k == 4) chk("cnt_first", 32'(strobe_cnt), 1);
    end
    chk("cnt_e9", 32'(strobe_cnt), 3);

    // Switch 0 -> 3: accepted at edge 10, divby_16 rises (7->8) and is seen at edge 24.
    sel_req = 1'b1; sel_new = 2'd3;
    tick();
    sel_req = 1'b0;
    chk("sw_busy_set", 32'(busy), 1);
    chk("sw_no_strobe_accept", 32'(strobe), 0);
    clr_counts();
    while (k < 23) begin tick(); acc_counts(); end
    chk("sw_pend_strobes", 32'(n_strb), 0);
    chk("sw_pend_acks", 32'(n_ack), 0);
    chk("sw_pend_busy", 32'(n_nbusy), 0);
    tick();
    chk("sw_strobe", 32'(strobe), 1);
    chk("sw_ack", 32'(sel_ack), 1);
    chk("sw_err", 32'(sel_err), 0);
    chk("sw_sel", 32'(sel_cur), 3);
    chk("sw_busy_clr", 32'(busy), 0);
    clr_counts();
    while (k < 39) begin tick(); acc_counts(); end
    chk("sel3_gap_strobes", 32'(n_strb), 0);
    tick();
    chk("sel3_period16", 32'(strobe), 1);

    // Same-tap request: immediate ack, no busy, cadence kept.
    run_to(43);
    sel_req = 1'b1; sel_new = 2'd3;
    tick();
    sel_req = 1'b0;
    chk("same_ack", 32'(sel_ack), 1);
    chk("same_err", 32'(sel_err), 0);
    chk("same_busy", 32'(busy), 0);
    clr_counts();
    while (k < 55) begin tick(); acc_counts(); end
    chk("same_ack_once", 32'(n_ack), 0);
    chk("same_never_busy", 32'(n_busy), 0);
    chk("same_gap_strobes", 32'(n_strb), 0);
    tick();
    chk("same_cadence", 32'(strobe), 1);

    // Frozen taps: request to 2 accepted at edge 61 must time out at edge 125.
    cnt_run = 1'b0; div_in = 4'd0;
    run_to(60);
    sel_req = 1'b1; sel_new = 2'd2;
    tick();
    sel_req = 1'b0;
    chk("to_busy_set", 32'(busy), 1);
    clr_counts();
    while (k < 124) begin
      tick();
      acc_counts();
      if (k == 69) begin sel_req = 1'b1; sel_new = 2'd3; end
      if (k == 70) sel_req = 1'b0;
    end
    chk("to_pend_acks", 32'(n_ack), 0);
    chk("to_pend_busy", 32'(n_nbusy), 0);
    chk("to_pend_strobes", 32'(n_strb), 0);
    tick();
    chk("to_ack", 32'(sel_ack), 1);
    chk("to_err", 32'(sel_err), 1);
    chk("to_sel_kept", 32'(sel_cur), 3);
    chk("to_busy_clr", 32'(busy), 0);
    clr_counts();
    while (k < 130) begin tick(); acc_counts(); end
    chk("to_ignored_req_acks", 32'(n_ack), 0);
    chk("to_after_busy", 32'(n_busy), 0);

    // Counter wrap and clear priority on a fresh run at tap 0.
    do_reset();
    rst = 1'b0; div_in = 4'd1; cnt_run = 1'b1; k = -1;
    run_to(4);
    chk("wrap_cnt_e4", 32'(strobe_cnt), 1);
    run_to(512);
    chk("wrap_cnt_255", 32'(strobe_cnt), 255);
    run_to(514);
    chk("wrap_cnt_0", 32'(strobe_cnt), 0);
    run_to(516);
    chk("wrap_cnt_1", 32'(strobe_cnt), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_plain", 32'(strobe_cnt), 0);
    chk("clr_strobe_present", 32'(strobe), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_priority", 32'(strobe_cnt), 0);
    run_to(520);
    chk("clr_then_count", 32'(strobe_cnt), 1);

    // Switch to 3, then freeze and abort a pending change with reset.
    sel_req = 1'b1; sel_new = 2'd3;
    tick();
    sel_req = 1'b0;
    tick();
    chk("rp_busy_a", 32'(busy), 1);
    run_to(536);
    chk("rp_sw_ack", 32'(sel_ack), 1);
    chk("rp_sw_sel", 32'(sel_cur), 3);
    cnt_run = 1'b0; div_in = 4'd0;
    run_to(539);
    sel_req = 1'b1; sel_new = 2'd1;
    tick();
    sel_req = 1'b0;
    run_to(544);
    chk("rp_busy_b", 32'(busy), 1);
    chk("rp_cnt_nonzero", 32'(strobe_cnt != 8'd0), 1);
    rst = 1'b1;
    tick();
    chk("rp_busy", 32'(busy), 0);
    chk("rp_ack", 32'(sel_ack), 0);
    chk("rp_sel", 32'(sel_cur), 0);
    chk("rp_cnt", 32'(strobe_cnt), 0);
    chk("rp_strobe", 32'(strobe), 0);
    tick();
    rst = 1'b0;
    clr_counts();
    for (int i = 0; i < 80; i++) begin tick(); acc_counts(); end
    chk("rp_dropped_acks", 32'(n_ack), 0);
    chk("rp_dropped_busy", 32'(n_busy), 0);
    chk("rp_sel_hold", 32'(sel_cur), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_strobe_sel.md
Name: div_strobe_sel

Overview:
- Downstream consumer of the clock-divider taps (divby_2/4/8/16), all in the same `clk` domain.
- Detects rising edges on the selected tap and emits a single-cycle strobe, usable as a clock enable.
- Supports a handshaked, glitch-free change of the selected ratio, plus a strobe event counter.
- No derived clocks leave this block; downstream logic uses `strobe` as an enable.

Parameters:
- CNT_W, 8, width of strobe_cnt.
- TIMEOUT, 64, cycles allowed in PENDING before a selection change is aborted (≥2).
- RST_SEL, 0, sel_cur value after reset (0..3).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- div_in  in  4  divider taps: bit0=divby_2, bit1=divby_4, bit2=divby_8, bit3=divby_16.
- sel_req  in  1  one-cycle request to change selection.
- sel_new  in  2  requested tap index, sampled when sel_req accepted.
- cnt_clr  in  1  synchronous clear of strobe_cnt.
- strobe  out  1  one-cycle pulse per rising edge of selected tap.
- sel_cur  out  2  currently active tap index.
- sel_ack  out  1  one-cycle pulse: request completed.
- sel_err  out  1  valid with sel_ack: 1 = aborted by timeout, sel_cur unchanged.
- busy  out  1  high in PENDING; requests ignored.
- strobe_cnt  out  CNT_W  strobes since reset/clear, wraps.

Behaviour:
- Reset values (rst high at posedge):
  - strobe=0, sel_ack=0, sel_err=0, busy=0, strobe_cnt=0, sel_cur=RST_SEL.
  - Sample registers d1=d2=0, primed=0, state=IDLE, timeout counter=0.
  - Reset overrides everything, including mid-PENDING; the pending request is dropped with no ack.
- Sampling and priming:
  - d1<=div_in; d2<=d1 every cycle.
  - edge[i] = d1[i] & ~d2[i] & primed.
  - primed sets 2 cycles after rst deasserts, which suppresses a false edge from the reset-time zero history.
- Latency: a tap rising at sample edge n gives strobe=1 for exactly the cycle after edge n+2 (registered output).
- IDLE:
  - strobe <= edge[sel_cur].
  - sel_req && sel_new==sel_cur → sel_ack=1, sel_err=0 next cycle; stay IDLE.
  - sel_req && sel_new!=sel_cur → latch sel_new into pend; timeout counter=0; go to PENDING; busy=1 from the next cycle.
- PENDING:
  - Strobes are suppressed entirely; no strobe from either the old or the new tap.
  - On the first cycle with edge[pend]=1:
    - sel_cur<=pend, strobe<=1, sel_ack<=1, sel_err<=0; return to IDLE.
    - The switch strobe is therefore a genuine full-period edge of the new tap; no runt or doubled strobe.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with no edge:
    - sel_ack<=1, sel_err<=1, sel_cur unchanged; return to IDLE.
  - sel_req while busy is ignored; it is neither queued nor acked.
- strobe_cnt:
  - +1 in the cycle strobe is asserted; wraps 2^CNT_W-1 → 0 with no flag.
  - cnt_clr has priority: when cnt_clr and strobe coincide, strobe_cnt=0.
- div_in is treated as synchronous to clk; no metastability handling. A frozen div_in (upstream en=0) yields no strobes and causes any pending change to time out.

Test Plan:
- rst, then div_in driven by a free-running 4-bit counter (+1/cycle), RST_SEL=0 → first strobe ≥3 cycles after rst release, then strobe every 2 cycles; no strobe in the first 2 post-reset cycles.
- Same stimulus, sel_req with sel_new=3 → busy=1; zero strobes until the counter wraps 7→8; then sel_ack=1, sel_err=0, strobe=1 and sel_cur=3 in the same cycle; thereafter strobe every 16 cycles.
- div_in held at 4'b0000, sel_req with sel_new=2 → sel_ack=1, sel_err=1 exactly TIMEOUT(64) cycles after acceptance; sel_cur stays 0; busy falls.
- sel_req with sel_new==sel_cur (1) → sel_ack=1, sel_err=0 on the next cycle; busy never asserts; strobe cadence uninterrupted. A second sel_req issued while busy produces no additional ack.
- Run until strobe_cnt=255 (CNT_W=8), next strobe → 0. Assert cnt_clr in the same cycle as a strobe → strobe_cnt=0, not 1.
- rst asserted mid-PENDING → next cycle busy=0, sel_ack=0, sel_cur=RST_SEL, strobe_cnt=0; the dropped request is never acked.
